rv32_mod_instruction_decoder_imm_pipe: RTL and testbench
========================================================

Name: rv32_mod_instruction_decoder_imm_pipe

Overview:
- Registered, flow-controlled immediate generator for the decode stage.
- Accepts a fetched 32-bit instruction and its one-hot format vector over a valid/ready handshake.
- Builds the sign-extended immediate at parametrised XLEN, with optional CSR zero-extended immediate (zimm) mode and format-error detection.
- Output goes through a 2-entry skid buffer, so back-pressure from execute never creates a combinational path to fetch.

Parameters:
- XLEN, 32, immediate width; legal values 32 or 64. Sign extension always comes from instruction[31].
- ZIMM_EN, 1, when 1 the in_csr_imm request is honoured; when 0 it is ignored.
- TAG_W, 5, width of the sideband tag carried alongside the immediate (rd/ROB index).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream offers an instruction.
- in_ready  output  1  block can accept an instruction; registered.
- in_instruction  input  32  raw instruction word.
- in_format  input  6  one-hot plus subtype flags, ordered {r, i, s, s_subtype_b, u, u_subtype_j}.
- in_csr_imm  input  1  request CSR zimm instead of the I immediate.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  immediate available.
- out_ready  input  1  downstream accepts.
- out_immediate  output  XLEN  decoded immediate.
- out_tag  output  TAG_W  tag of the out_immediate entry.
- out_format_err  output  1  in_format was not a legal encoding.

Behaviour:
- Legal in_format values, with imm = sext to XLEN:
  - R = 100000: imm = 0.
  - I = 010000: imm = sext(ins[31:20]).
  - S = 001000: imm = sext({ins[31:25], ins[11:7]}).
  - B = 001100: imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}).
  - U = 000010: imm = sext({ins[31:12], 12'b0}); bits XLEN-1:32 copy ins[31] when XLEN=64.
  - J = 000011: imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}).
- Any other in_format value: out_format_err = 1, out_immediate = 0.
- zimm, when ZIMM_EN=1 and in_csr_imm=1:
  - Format I: imm = zext(ins[19:15]).
  - Any other format: out_format_err = 1, imm = 0.
- zimm, when ZIMM_EN=0: in_csr_imm has no effect.
- Handshake:
  - Transfer occurs when valid && ready are both high at a clock edge.
  - Once out_valid is asserted, out_immediate, out_tag and out_format_err stay stable until out_ready is seen.
- Latency: an accepted input appears on out_* in the following cycle. Sustained throughput is 1 per cycle while out_ready=1.
- Storage:
  - Main register drives out_* directly.
  - Skid register captures an accepted input when the main register is valid and not draining (out_valid && !out_ready).
  - in_ready = !skid_valid, registered, with no combinational in-to-out path.
  - When main drains and skid is valid, skid moves into main in the same edge; any new input lands in skid.
- Order: strict FIFO; entries are never reordered or dropped except by flush.
- Full (skid_valid=1): in_ready=0. An input offered during this time is not taken and must be held by upstream.
- Simultaneous transfer in and out with skid empty: main reloads with the new entry and out_valid stays 1.
- flush:
  - At the next edge, main and skid valid bits clear and in_ready=1.
  - An input offered in the flush cycle is discarded, even if in_valid && in_ready.
  - flush has priority over all other events.
- Reset (rstn=0, asynchronous):
  - out_valid=0, out_immediate=0, out_tag=0, out_format_err=0, skid_valid=0, in_ready=1.
  - Reset taken mid-transfer drops all held entries.
  - After release, the block accepts input on the first edge.
- Data registers are cleared only by reset; they need not clear on flush.

Test Plan:
- Single-entry decode, XLEN=32, out_ready=1:
  - I, ins=0xFFF00093 -> one cycle later out_immediate=0xFFFFFFFF.
  - B, ins=0x8000_0063 -> 0xFFFFF000.
  - J, ins=0x0010_006F -> 0x00000800.
  - S, ins=0xFE00_2FA3 -> 0xFFFFFFFF.
  - U, ins=0x1234_5037 -> 0x12345000.
- XLEN=64, U format, ins=0x8000_0037 -> out_immediate=0xFFFFFFFF80000000.
- zimm, ZIMM_EN=1, I format, in_csr_imm=1, ins[19:15]=5'h1F, ins[31]=1 -> imm=0x1F, err=0.
- zimm with S format -> err=1, imm=0.
- Illegal format 010100 -> err=1, imm=0.
- Back-pressure:
  - Stream tags 1,2,3 with out_ready=0 -> in_ready drops after tag 2 is accepted; tag 3 is held upstream.
  - Raise out_ready -> out_tag sequence is 1, 2, 3 with no gaps or duplicates.
- flush with both entries full -> next cycle out_valid=0, in_ready=1; the input offered in the flush cycle never appears at the output.
- Assert rstn=0 asynchronously mid-stream (between edges) -> out_valid falls immediately. After release, in_ready=1 and the first new input emerges with latency 1.

Source files
------------

// File: rtl/rv32_mod_instruction_decoder_imm_pipe_if.sv
// ---------------------------------------------------------------------------
// rv32_mod_instruction_decoder_imm_pipe_if
// Purpose: groups the fetch-side and execute-side handshake signals of the
//          decode-stage immediate generator into one bundle.
// Signals:
//   in_valid / in_ready        fetch-side handshake
//   in_instruction [31:0]      raw instruction word
//   in_format [5:0]            {r, i, s, s_subtype_b, u, u_subtype_j}
//   in_csr_imm                 request CSR zimm instead of the I immediate
//   in_tag [TAG_W-1:0]         sideband (rd / ROB index)
//   out_valid / out_ready      execute-side handshake
//   out_immediate [XLEN-1:0]   decoded immediate
//   out_tag [TAG_W-1:0]        tag belonging to out_immediate
//   out_format_err             in_format / zimm combination was illegal
// Modports: master = producer of instructions / consumer of immediates,
//           slave  = the immediate generator itself.
// ---------------------------------------------------------------------------
interface rv32_mod_instruction_decoder_imm_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instruction;
    logic [5:0]       in_format;
    logic             in_csr_imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_immediate;
    logic [TAG_W-1:0] out_tag;
    logic             out_format_err;

    modport master (
        output in_valid, in_instruction, in_format, in_csr_imm, in_tag, out_ready,
        input  in_ready, out_valid, out_immediate, out_tag, out_format_err
    );

    modport slave (
        input  in_valid, in_instruction, in_format, in_csr_imm, in_tag, out_ready,
        output in_ready, out_valid, out_immediate, out_tag, out_format_err
    );
endinterface

// File: rtl/rv32_mod_instruction_decoder_imm_pipe.sv
// ---------------------------------------------------------------------------
// rv32_mod_instruction_decoder_imm_pipe
// Purpose: registered, flow-controlled RV32 immediate generator. Decodes the
//          immediate of an accepted instruction and presents it one cycle
//          later through a 2-entry (main + skid) buffer so that out_ready
//          never reaches in_ready combinationally.
// Parameters:
//   XLEN    immediate width (32 or 64), sign taken from instruction[31]
//   ZIMM_EN when 1, in_csr_imm selects the zero-extended CSR immediate
//   TAG_W   width of the sideband tag
// Ports:
//   clk    rising-edge clock
//   rstn   asynchronous active-low reset
//   flush  synchronous flush, highest priority, drops held entries and the
//          input offered in the same cycle
//   bus    slave side of rv32_mod_instruction_decoder_imm_pipe_if
// ---------------------------------------------------------------------------
module rv32_mod_instruction_decoder_imm_pipe #(
    parameter int XLEN    = 32,
    parameter bit ZIMM_EN = 1'b1,
    parameter int TAG_W   = 5
) (
    input  logic clk,
    input  logic rstn,
    input  logic flush,
    rv32_mod_instruction_decoder_imm_pipe_if.slave bus
);

    localparam logic [5:0] FMT_R = 6'b100000;
    localparam logic [5:0] FMT_I = 6'b010000;
    localparam logic [5:0] FMT_S = 6'b001000;
    localparam logic [5:0] FMT_B = 6'b001100;
    localparam logic [5:0] FMT_U = 6'b000010;
    localparam logic [5:0] FMT_J = 6'b000011;

    logic [31:0]      ins;
    logic             use_zimm;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;

    logic             main_valid;
    logic [XLEN-1:0]  main_imm;
    logic [TAG_W-1:0] main_tag;
    logic             main_err;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;

    logic             main_free;
    logic             accept;

    // Every immediate is first formed as a 32-bit value whose bit 31 is
    // instruction[31]; widening that value signed gives the XLEN result.
    function automatic logic [XLEN-1:0] widen(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign ins      = bus.in_instruction;
    assign use_zimm = ZIMM_EN && bus.in_csr_imm;

    // Immediate decode. Illegal formats, and zimm on anything but I,
    // report an error with a zero immediate.
    always_comb begin
        dec_imm = '0;
        dec_err = 1'b0;
        if (use_zimm) begin
            if (bus.in_format == FMT_I) begin
                dec_imm = XLEN'(ins[19:15]);
            end else begin
                dec_err = 1'b1;
            end
        end else begin
            case (bus.in_format)
                FMT_R:   dec_imm = '0;
                FMT_I:   dec_imm = widen({{20{ins[31]}}, ins[31:20]});
                FMT_S:   dec_imm = widen({{20{ins[31]}}, ins[31:25], ins[11:7]});
                FMT_B:   dec_imm = widen({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                FMT_U:   dec_imm = widen({ins[31:12], 12'b0});
                FMT_J:   dec_imm = widen({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                default: dec_err = 1'b1;
            endcase
        end
    end

    // in_ready is simply the inverse of the skid flop, so it is registered
    // and independent of out_ready in the current cycle.
    assign bus.in_ready = !skid_valid;
    assign main_free    = !main_valid || bus.out_ready;
    assign accept       = bus.in_valid && !skid_valid && !flush;

    // Main/skid buffer. When main frees up the skid entry moves in first to
    // keep FIFO order; a new input only goes to skid while main is stalled.
    // Accepting is impossible while skid is full, so the skid-to-main move
    // never competes with a new input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_imm   <= skid_imm;
                main_tag   <= skid_tag;
                main_err   <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_imm   <= dec_imm;
                main_tag   <= bus.in_tag;
                main_err   <= dec_err;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_tag   <= bus.in_tag;
            skid_err   <= dec_err;
        end
    end

    assign bus.out_valid      = main_valid;
    assign bus.out_immediate  = main_imm;
    assign bus.out_tag        = main_tag;
    assign bus.out_format_err = main_err;

endmodule

// File: tb/tb_rv32_mod_instruction_decoder_imm_pipe.sv
// ---------------------------------------------------------------------------
// tb_rv32_mod_instruction_decoder_imm_pipe
// Purpose: self-checking bench for the immediate generator. One instance at
//          XLEN=32 with zimm enabled, one at XLEN=64 with zimm disabled.
//          Expected immediates come from an arithmetic reference model and a
//          queue-based occupancy model of the 2-entry buffer.
// ---------------------------------------------------------------------------
module tb_rv32_mod_instruction_decoder_imm_pipe;

    typedef struct {
        logic [4:0]  tag;
        logic        err;
        logic [63:0] imm;
    } entry_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rv32_mod_instruction_decoder_imm_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    rv32_mod_instruction_decoder_imm_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

    rv32_mod_instruction_decoder_imm_pipe #(.XLEN(32), .ZIMM_EN(1'b1), .TAG_W(5)) dut32 (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(bus32)
    );

    rv32_mod_instruction_decoder_imm_pipe #(.XLEN(64), .ZIMM_EN(1'b0), .TAG_W(5)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(bus64)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference immediate: fields gathered as plain numbers, made negative
    // by subtracting 2^width when the top bit is set, then truncated to XLEN.
    // Returns {err, imm[63:0]}.
    function automatic logic [64:0] ref_imm(input logic [31:0] ins, input logic [5:0] fmt,
                                            input logic csr, input bit zimm_en, input int xlen);
        longint v = 0;
        bit     err = 0;
        if (zimm_en && csr) begin
            if (fmt == 6'b010000) v = longint'(ins[19:15]);
            else err = 1;
        end else if (fmt == 6'b100000) begin
            v = 0;
        end else if (fmt == 6'b010000) begin
            v = longint'(ins[31:20]);
            if (v >= 2048) v = v - 4096;
        end else if (fmt == 6'b001000) begin
            v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
            if (v >= 2048) v = v - 4096;
        end else if (fmt == 6'b001100) begin
            v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
              + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            if (v >= 4096) v = v - 8192;
        end else if (fmt == 6'b000010) begin
            v = longint'(ins[31:12]) * 4096;
            if (ins[31]) v = v - 64'sh1_0000_0000;
        end else if (fmt == 6'b000011) begin
            v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
              + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            if (v >= 1048576) v = v - 2097152;
        end else begin
            err = 1;
        end
        if (err) v = 0;
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return {err, 64'(v)};
    endfunction

    function automatic logic [5:0] pick_format();
        logic [5:0] legal [6] = '{6'b100000, 6'b010000, 6'b001000, 6'b001100, 6'b000010, 6'b000011};
        int r = $urandom_range(0, 7);
        if (r < 6) return legal[r];
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic test_reset();
        #12;
        tests++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_tag !== 5'd0 ||
            bus32.out_immediate !== 32'd0 || bus32.out_format_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_state: got v=%b r=%b tag=%0d imm=%h err=%b expected v=0 r=1 tag=0 imm=0 err=0",
                     bus32.out_valid, bus32.in_ready, bus32.out_tag, bus32.out_immediate, bus32.out_format_err);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        tests++;
        if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_release: got r=%b v=%b expected r=1 v=0", bus32.in_ready, bus32.out_valid);
        end
    endtask

    task automatic decode_one(input string name, input logic [31:0] ins, input logic [5:0] fmt,
                              input logic csr, input logic [4:0] tag,
                              input logic [31:0] exp_imm, input logic exp_err);
        bus32.in_instruction = ins;
        bus32.in_format      = fmt;
        bus32.in_csr_imm     = csr;
        bus32.in_tag         = tag;
        bus32.in_valid       = 1'b1;
        bus32.out_ready      = 1'b1;
        step();
        bus32.in_valid = 1'b0;
        tests++;
        if (bus32.out_valid !== 1'b1 || bus32.out_tag !== tag) begin
            fails++;
            $display("[TB] FAIL %s_valid_tag: got v=%b tag=%0d expected v=1 tag=%0d", name, bus32.out_valid, bus32.out_tag, tag);
        end
        tests++;
        if (bus32.out_immediate !== exp_imm || bus32.out_format_err !== exp_err) begin
            fails++;
            $display("[TB] FAIL %s_imm: got imm=%h err=%b expected imm=%h err=%b",
                     name, bus32.out_immediate, bus32.out_format_err, exp_imm, exp_err);
        end
        step();
    endtask

    task automatic test_decode();
        decode_one("dec_I", 32'hFFF0_0093, 6'b010000, 1'b0, 5'd1, 32'hFFFF_FFFF, 1'b0);
        decode_one("dec_B", 32'h8000_0063, 6'b001100, 1'b0, 5'd2, 32'hFFFF_F000, 1'b0);
        decode_one("dec_J", 32'h0010_006F, 6'b000011, 1'b0, 5'd3, 32'h0000_0800, 1'b0);
        decode_one("dec_S", 32'hFE00_2FA3, 6'b001000, 1'b0, 5'd4, 32'hFFFF_FFFF, 1'b0);
        decode_one("dec_U", 32'h1234_5037, 6'b000010, 1'b0, 5'd5, 32'h1234_5000, 1'b0);
        decode_one("dec_R", 32'hFFFF_FFB3, 6'b100000, 1'b0, 5'd6, 32'h0000_0000, 1'b0);
        decode_one("illegal_fmt", 32'hFFF0_0093, 6'b010100, 1'b0, 5'd7, 32'h0000_0000, 1'b1);
    endtask

    task automatic test_zimm();
        decode_one("zimm_I", 32'h800F_8073, 6'b010000, 1'b1, 5'd8, 32'h0000_001F, 1'b0);
        decode_one("zimm_S", 32'h800F_8073, 6'b001000, 1'b1, 5'd9, 32'h0000_0000, 1'b1);
    endtask

    task automatic test_xlen64();
        logic [31:0] ins_list [3] = '{32'h8000_0037, 32'hFFF0_0093, 32'h0010_006F};
        logic [5:0]  fmt_list [3] = '{6'b000010, 6'b010000, 6'b000011};
        logic [63:0] exp_list [3] = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0800};
        logic [64:0] r;
        bus64.out_ready = 1'b1;
        // Directed cases; the I case requests zimm, which this instance ignores.
        for (int i = 0; i < 3; i++) begin
            bus64.in_instruction = ins_list[i];
            bus64.in_format      = fmt_list[i];
            bus64.in_csr_imm     = 1'b1;
            bus64.in_tag         = 5'(i + 20);
            bus64.in_valid       = 1'b1;
            step();
            bus64.in_valid = 1'b0;
            tests++;
            if (bus64.out_valid !== 1'b1 || bus64.out_immediate !== exp_list[i] || bus64.out_format_err !== 1'b0) begin
                fails++;
                $display("[TB] FAIL x64_directed_%0d: got v=%b imm=%h err=%b expected v=1 imm=%h err=0",
                         i, bus64.out_valid, bus64.out_immediate, bus64.out_format_err, exp_list[i]);
            end
        end
        // Random decodes, one per cycle, out_ready held high.
        for (int i = 0; i < 40; i++) begin
            bus64.in_instruction = $urandom;
            bus64.in_format      = pick_format();
            bus64.in_csr_imm     = 1'($urandom_range(0, 1));
            bus64.in_valid       = 1'b1;
            r = ref_imm(bus64.in_instruction, bus64.in_format, bus64.in_csr_imm, 1'b0, 64);
            step();
            tests++;
            if (bus64.out_valid !== 1'b1 || bus64.out_immediate !== r[63:0] || bus64.out_format_err !== r[64]) begin
                fails++;
                $display("[TB] FAIL x64_random_%0d: got v=%b imm=%h err=%b expected v=1 imm=%h err=%b",
                         i, bus64.out_valid, bus64.out_immediate, bus64.out_format_err, r[63:0], r[64]);
            end
        end
        bus64.in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bus32.out_ready  = 1'b1;
        bus32.in_format  = 6'b010000;
        bus32.in_csr_imm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus32.in_instruction = 32'(i) << 20;
            bus32.in_tag         = 5'(i + 10);
            bus32.in_valid       = 1'b1;
            step();
            tests++;
            if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'(i + 10) ||
                bus32.out_immediate !== 32'(i) || bus32.in_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL b2b_%0d: got v=%b tag=%0d imm=%h r=%b expected v=1 tag=%0d imm=%h r=1",
                         i, bus32.out_valid, bus32.out_tag, bus32.out_immediate, bus32.in_ready, i + 10, i);
            end
        end
        bus32.in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [4:0] got [$];
        bit acc;
        bus32.out_ready = 1'b0;
        bus32.in_format = 6'b100000;
        bus32.in_valid  = 1'b1;
        bus32.in_tag    = 5'd1;
        step();
        bus32.in_tag = 5'd2;
        step();
        tests++;
        if (bus32.in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_full_ready: got %b expected 0", bus32.in_ready);
        end
        bus32.in_tag = 5'd3;
        step();
        tests++;
        if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'd1) begin
            fails++;
            $display("[TB] FAIL bp_hold: got r=%b v=%b tag=%0d expected r=0 v=1 tag=1",
                     bus32.in_ready, bus32.out_valid, bus32.out_tag);
        end
        bus32.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (bus32.out_valid === 1'b1) got.push_back(bus32.out_tag);
            acc = bus32.in_valid && bus32.in_ready;
            step();
            if (acc) bus32.in_valid = 1'b0;
        end
        tests++;
        if (got.size() != 3) begin
            fails++;
            $display("[TB] FAIL bp_count: got %0d entries expected 3", got.size());
        end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            tests++;
            if (got[i] !== 5'(i + 1)) begin
                fails++;
                $display("[TB] FAIL bp_order_%0d: got tag %0d expected %0d", i, got[i], i + 1);
            end
        end
        bus32.in_valid = 1'b0;
    endtask

    task automatic test_flush();
        bus32.out_ready = 1'b0;
        bus32.in_format = 6'b010000;
        bus32.in_valid  = 1'b1;
        bus32.in_tag    = 5'd4;
        step();
        bus32.in_tag = 5'd5;
        step();
        flush        = 1'b1;
        bus32.in_tag = 5'd7;
        step();
        flush          = 1'b0;
        bus32.in_valid = 1'b0;
        tests++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL flush_full: got v=%b r=%b expected v=0 r=1", bus32.out_valid, bus32.in_ready);
        end
        // Flush while empty and ready: the offered input must still vanish.
        bus32.out_ready = 1'b1;
        flush           = 1'b1;
        bus32.in_valid  = 1'b1;
        bus32.in_tag    = 5'd8;
        step();
        flush          = 1'b0;
        bus32.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (bus32.out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL flush_discard_%0d: got v=%b tag=%0d expected v=0", c, bus32.out_valid, bus32.out_tag);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        bus32.out_ready      = 1'b0;
        bus32.in_format      = 6'b010000;
        bus32.in_instruction = 32'h0050_0000;
        bus32.in_valid       = 1'b1;
        bus32.in_tag         = 5'd9;
        step();
        bus32.in_tag = 5'd10;
        #3;
        rstn = 1'b0;
        #1;
        tests++;
        if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_tag !== 5'd0 || bus32.out_immediate !== 32'd0) begin
            fails++;
            $display("[TB] FAIL async_reset: got v=%b r=%b tag=%0d imm=%h expected v=0 r=1 tag=0 imm=0",
                     bus32.out_valid, bus32.in_ready, bus32.out_tag, bus32.out_immediate);
        end
        #2;
        rstn            = 1'b1;
        bus32.out_ready = 1'b1;
        bus32.in_tag    = 5'd11;
        step();
        bus32.in_valid = 1'b0;
        tests++;
        if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'd11 || bus32.out_immediate !== 32'd5) begin
            fails++;
            $display("[TB] FAIL post_reset_first: got v=%b tag=%0d imm=%h expected v=1 tag=11 imm=5",
                     bus32.out_valid, bus32.out_tag, bus32.out_immediate);
        end
        step();
    endtask

    task automatic test_random();
        entry_t      q [$];
        entry_t      cur;
        logic [64:0] r;
        logic [4:0]  tag;
        bit          hold, acc, pop, fl;
        tag  = 5'd0;
        hold = 1'b0;
        cur  = '{tag: 5'd0, err: 1'b0, imm: 64'd0};
        bus32.in_valid = 1'b0;
        flush          = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tests++;
            if (bus32.out_valid !== (q.size() > 0) || bus32.in_ready !== (q.size() < 2)) begin
                fails++;
                $display("[TB] FAIL rand_occupancy_%0d: got v=%b r=%b expected entries=%0d",
                         c, bus32.out_valid, bus32.in_ready, q.size());
            end
            if (q.size() > 0) begin
                tests++;
                if (bus32.out_tag !== q[0].tag || bus32.out_format_err !== q[0].err ||
                    bus32.out_immediate !== q[0].imm[31:0]) begin
                    fails++;
                    $display("[TB] FAIL rand_data_%0d: got tag=%0d imm=%h err=%b expected tag=%0d imm=%h err=%b",
                             c, bus32.out_tag, bus32.out_immediate, bus32.out_format_err,
                             q[0].tag, q[0].imm[31:0], q[0].err);
                end
            end
            if (!hold) begin
                tag                  = tag + 5'd1;
                bus32.in_valid       = ($urandom_range(0, 3) != 0);
                bus32.in_instruction = $urandom;
                bus32.in_format      = pick_format();
                bus32.in_csr_imm     = ($urandom_range(0, 3) == 0);
                bus32.in_tag         = tag;
            end
            fl              = ($urandom_range(0, 29) == 0);
            flush           = fl;
            bus32.out_ready = ($urandom_range(0, 2) != 0);
            acc = bus32.in_valid && (q.size() < 2) && !fl;
            pop = bus32.out_ready && (q.size() > 0) && !fl;
            if (acc) begin
                r       = ref_imm(bus32.in_instruction, bus32.in_format, bus32.in_csr_imm, 1'b1, 32);
                cur.tag = tag;
                cur.err = r[64];
                cur.imm = r[63:0];
            end
            step();
            flush = 1'b0;
            if (fl) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(cur);
            end
            hold = bus32.in_valid && !acc && !fl;
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        step();
    endtask

    initial begin
        bus32.in_valid = 1'b0; bus32.in_instruction = '0; bus32.in_format = '0;
        bus32.in_csr_imm = 1'b0; bus32.in_tag = '0; bus32.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_instruction = '0; bus64.in_format = '0;
        bus64.in_csr_imm = 1'b0; bus64.in_tag = '0; bus64.out_ready = 1'b0;
        test_reset();
        test_decode();
        test_zimm();
        test_xlen64();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
